wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending write entries (power of two, >= 2).
REQ-002 SHALL have parameter XLEN, default 64, meaning data width of a register write.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 SHALL have port wb_valid  input  1  producer presents a writeback request.
REQ-006 SHALL have port wb_ready  output  1  queue can accept a request this cycle.
REQ-007 SHALL have port wb_rd  input  5  destination register index of the request.
REQ-008 SHALL have port wb_data  input  XLEN  data of the request.
REQ-009 SHALL have port rf_we  output  1  register-file write enable (drives RegWrite).
REQ-010 SHALL have port rf_waddr  output  5  register-file write index (drives WriteReg).
REQ-011 SHALL have port rf_wdata  output  XLEN  register-file write data (drives WriteData).
REQ-012 SHALL have ports fwd_addr1, fwd_addr2  input  5 each  source indices being read from the register file this cycle.
REQ-013 SHALL have ports fwd_hit1, fwd_hit2  output  1 each  pending queued write matches the corresponding source index.
REQ-014 SHALL have ports fwd_data1, fwd_data2  output  XLEN each  forwarded data for the corresponding source index.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid queued entries.

Function
REQ-016 SHALL be a FIFO of DEPTH entries {rd, data}, in-order, with head/tail pointers wrapping modulo DEPTH.
REQ-017 SHALL drive wb_ready = 1 exactly when count < DEPTH and rst=1; no pass-through when full, even if a pop occurs the same cycle.
REQ-018 SHALL treat a handshake as wb_valid=1 and wb_ready=1 at a rising edge; only then is the request consumed.
REQ-019 SHALL consume and discard a handshaked request with wb_rd=0 (x0): no enqueue, count unchanged by it.
REQ-020 SHALL enqueue a handshaked request with wb_rd!=0 at the tail on that edge.
REQ-021 SHALL drive rf_we=1, rf_waddr=head.rd, rf_wdata=head.data combinationally whenever count>0; rf_we=0, rf_waddr=0, rf_wdata=0 when count=0.
REQ-022 SHALL pop the head on every rising edge at which count>0 (register file captures the write on the same edge); drain rate one entry per cycle.
REQ-023 SHALL give latency: request handshaked at edge N into an empty queue appears on rf_* during cycle N..N+1 and is written at edge N+1.
REQ-024 SHALL keep count unchanged on a simultaneous enqueue and pop, increment on enqueue only, decrement on pop only.
REQ-025 SHALL assert fwd_hitK=1 when fwd_addrK!=0 and any valid entry has rd==fwd_addrK; fwd_dataK SHALL be the data of the youngest (closest to tail) matching entry.
REQ-026 SHALL drive fwd_hitK=0, fwd_dataK=0 when fwd_addrK=0 or no valid entry matches; the in-flight wb_* request is not forwarded.
REQ-027 SHALL include the head entry in forwarding during the cycle it is presented on rf_*.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear head, tail and count to 0, forcing rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit1=fwd_hit2=0, wb_ready=0.
REQ-029 SHALL discard all pending entries when rst falls mid-operation; no write reaches rf_* after reset asserts.
REQ-030 SHALL not require entry storage to be reset; invalid entries never affect outputs.
REQ-031 SHALL drive wb_ready=1 in the first cycle after rst rises.

Verification
REQ-032 Single write: empty queue, handshake rd=5 data=0xAB at edge N -> cycle after N rf_we=1 rf_waddr=5 rf_wdata=0xAB; edge N+1 count returns 0, rf_we=0.
REQ-033 Fill: wb_valid held with rd=1..6 while pops occur; with DEPTH=4, rd data distinct -> rf_* emits rd 1..6 in order, no loss or duplicate, wb_ready never 1 while count=4.
REQ-034 x0 drop: handshake rd=0 data=0xFFFF -> wb_ready=1, count stays 0, rf_we stays 0.
REQ-035 Forwarding: queue holds rd=7 data=0x11 then rd=7 data=0x22; fwd_addr1=7, fwd_addr2=0 -> fwd_hit1=1 fwd_data1=0x22, fwd_hit2=0 fwd_data2=0.
REQ-036 Reset mid-operation: count=3, drive rst=0 between edges -> immediately count=0, rf_we=0, wb_ready=0; after rst=1, next handshake rd=9 is the first rf_* write.

Source files
------------

// File: rtl/wb_write_queue.sv
// wb_write_queue
//   In-order writeback queue that sits between a producer of register writes
//   and the register file write port.  Each accepted request {rd, data} is
//   queued and drained to the register file at one entry per clock.  Pending
//   entries can be forwarded to two read ports so that a reader never sees a
//   stale register value while its write is still queued.
//
// Handshake: a request is consumed at a rising edge of clk when wb_valid and
//   wb_ready are both 1 at that edge.  wb_ready depends only on queue
//   occupancy and reset, never on wb_valid.  Requests to x0 are consumed and
//   dropped.
//
// Ports
//   clk                    single clock, rising edge
//   rst                    asynchronous, active-low reset
//   wb_valid/wb_ready      writeback request handshake
//   wb_rd, wb_data         destination index and data of the request
//   rf_we/rf_waddr/rf_wdata  register-file write port (head of queue)
//   fwd_addr1/2            source indices being read this cycle
//   fwd_hit1/2, fwd_data1/2  forwarded data from the youngest matching entry
//   count                  number of valid queued entries
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [4:0]               fwd_addr1,
    input  logic [4:0]               fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [XLEN-1:0]          fwd_data1,
    output logic [XLEN-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage is not reset: only slots inside [head, head+count) are
    // ever looked at.
    logic [4:0]      rdMem   [DEPTH];
    logic [XLEN-1:0] dataMem [DEPTH];

    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;

    logic doPush;
    logic doPop;
    logic notEmpty;

    assign notEmpty = (count != '0);

    // Full means no acceptance, even if the head pops on the same edge.
    assign wb_ready = rst && (count < CW'(DEPTH));
    assign doPush   = wb_valid && wb_ready && (wb_rd != 5'd0);
    assign doPop    = notEmpty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            rdMem[tailPtr]   <= wb_rd;
            dataMem[tailPtr] <= wb_data;
        end
    end

    // The head is presented combinationally; the register file captures it
    // on the same edge that pops it.
    assign rf_we    = notEmpty;
    assign rf_waddr = notEmpty ? rdMem[headPtr]   : 5'd0;
    assign rf_wdata = notEmpty ? dataMem[headPtr] : '0;

    // Forwarding walks entries oldest to youngest so a later match overrides
    // an earlier one, leaving the youngest matching entry's data.  The head is
    // still included while it is being written.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if ((fwd_addr1 != 5'd0) && (rdMem[headPtr + PW'(i)] == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = dataMem[headPtr + PW'(i)];
                end
                if ((fwd_addr2 != 5'd0) && (rdMem[headPtr + PW'(i)] == fwd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = dataMem[headPtr + PW'(i)];
                end
            end
        end
    end

endmodule
